// File: rtl/riscv_commit_checker_pkg.sv
// Shared encodings for the commit checker: FSM states, error codes and
// expected-entry kinds.
package riscv_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_SIMUL    = 2'd3;

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;

endpackage

// File: rtl/riscv_commit_checker_exp_mem.sv
// Expected-commit table: one {kind, addr, data} record per entry, written
// synchronously while loading and read combinationally at the compare pointer.
module chk_exp_mem #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic             wkind_i,
  input  logic [XLEN-1:0]  wentry_addr_i,
  input  logic [XLEN-1:0]  wentry_data_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic             rkind_o,
  output logic [XLEN-1:0]  rentry_addr_o,
  output logic [XLEN-1:0]  rentry_data_o
);

  logic [2*XLEN:0] entries_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      entries_q[waddr_i] <= {wkind_i, wentry_addr_i, wentry_data_i};
    end
  end

  assign {rkind_o, rentry_addr_o, rentry_data_o} = entries_q[raddr_i];

endmodule

// File: rtl/riscv_commit_checker.sv
// Self-check harness: compares a core's committed register writes and stores,
// in order, against a preloaded table of expected commits.
module riscv_commit_checker
  import riscv_chk_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = 1024,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             ld_kind,
  input  logic [XLEN-1:0]  ld_addr,
  input  logic [XLEN-1:0]  ld_data,
  input  logic             start,
  input  logic             obs_reg_we,
  input  logic [4:0]       obs_reg_addr,
  input  logic [XLEN-1:0]  obs_reg_data,
  input  logic             obs_mem_we,
  input  logic [XLEN-1:0]  obs_mem_addr,
  input  logic [XLEN-1:0]  obs_mem_data,
  output logic             done,
  output logic             pass,
  output logic [1:0]       err_code,
  output logic [IDX_W-1:0] fail_idx,
  output logic [XLEN-1:0]  fail_got,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef logic [IDX_W:0]   cnt_t;
  typedef logic [CNT_W-1:0] cyc_t;

  localparam cnt_t CNT_ZERO  = cnt_t'(0);
  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam cnt_t CNT_DEPTH = cnt_t'(DEPTH);
  localparam cyc_t CYC_ZERO  = cyc_t'(0);
  localparam cyc_t CYC_ONE   = cyc_t'(1);
  localparam cyc_t CYC_LAST  = cyc_t'(TIMEOUT - 1);
  localparam cyc_t CYC_MAX   = cyc_t'(TIMEOUT);

  chk_state_e       state_q;
  cnt_t             count_q;
  cnt_t             ptr_q;
  cyc_t             cyc_q;
  logic             done_q;
  logic             pass_q;
  logic [1:0]       err_q;
  logic [IDX_W-1:0] fidx_q;
  logic [XLEN-1:0]  fgot_q;

  logic            ld_fire;
  logic            reg_ev;
  logic            mem_ev;
  logic            ent_kind;
  logic [XLEN-1:0] ent_addr;
  logic [XLEN-1:0] ent_data;
  logic            match;
  logic [XLEN-1:0] ev_data;

  assign ld_ready = (state_q == ST_IDLE) && (count_q < CNT_DEPTH) && !rst;
  assign ld_fire  = ld_valid && ld_ready;
  assign reg_ev   = obs_reg_we && (obs_reg_addr != 5'd0);
  assign mem_ev   = obs_mem_we;

  chk_exp_mem #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_exp_mem (
    .clk_i         (clk),
    .we_i          (ld_fire),
    .waddr_i       (count_q[IDX_W-1:0]),
    .wkind_i       (ld_kind),
    .wentry_addr_i (ld_addr),
    .wentry_data_i (ld_data),
    .raddr_i       (ptr_q[IDX_W-1:0]),
    .rkind_o       (ent_kind),
    .rentry_addr_o (ent_addr),
    .rentry_data_o (ent_data)
  );

  // Register entries are matched on the 5-bit index only; stores on the full address.
  always_comb begin
    match   = 1'b0;
    ev_data = reg_ev ? obs_reg_data : obs_mem_data;
    if (reg_ev) begin
      match = (ent_kind == KIND_REG) && (ent_addr[4:0] == obs_reg_addr) &&
              (ent_data == obs_reg_data);
    end else if (mem_ev) begin
      match = (ent_kind == KIND_MEM) && (ent_addr == obs_mem_addr) &&
              (ent_data == obs_mem_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= CNT_ZERO;
      ptr_q   <= CNT_ZERO;
      cyc_q   <= CYC_ZERO;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= ERR_NONE;
      fidx_q  <= '0;
      fgot_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ld_fire) count_q <= count_q + CNT_ONE;
          // A load in the same cycle as start counts toward the table.
          if (start) begin
            if ((count_q == CNT_ZERO) && !ld_fire) begin
              state_q <= ST_PASS;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              ptr_q   <= CNT_ZERO;
              cyc_q   <= CYC_ZERO;
            end
          end
        end
        ST_RUN: begin
          if (cyc_q != CYC_MAX) cyc_q <= cyc_q + CYC_ONE;
          if (reg_ev && mem_ev) begin
            state_q <= ST_FAIL;
            done_q  <= 1'b1;
            err_q   <= ERR_SIMUL;
            fidx_q  <= ptr_q[IDX_W-1:0];
          end else if (reg_ev || mem_ev) begin
            if (match) begin
              ptr_q <= ptr_q + CNT_ONE;
              if (ptr_q == count_q - CNT_ONE) begin
                state_q <= ST_PASS;
                done_q  <= 1'b1;
                pass_q  <= 1'b1;
              end
            end else begin
              state_q <= ST_FAIL;
              done_q  <= 1'b1;
              err_q   <= ERR_MISMATCH;
              fidx_q  <= ptr_q[IDX_W-1:0];
              fgot_q  <= ev_data;
            end
          end else if (cyc_q >= CYC_LAST) begin
            state_q <= ST_FAIL;
            done_q  <= 1'b1;
            err_q   <= ERR_TIMEOUT;
            fidx_q  <= ptr_q[IDX_W-1:0];
          end
        end
        ST_PASS, ST_FAIL: begin
          if (start) begin
            state_q <= ST_IDLE;
            count_q <= CNT_ZERO;
            ptr_q   <= CNT_ZERO;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= ERR_NONE;
            fidx_q  <= '0;
            fgot_q  <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign err_code  = err_q;
  assign fail_idx  = fidx_q;
  assign fail_got  = fgot_q;
  assign cycle_cnt = cyc_q;

endmodule

// File: doc/riscv_commit_checker.md
Name: riscv_commit_checker

Overview:
- Synthesizable, parametrised self-check harness that sits beside Single_Cycle_Top, either in the bench or on an FPGA build.
- Replaces waveform inspection with an expected-commit table: the table is loaded first, then the block compares every observed register write and memory store, in order, against it.
- Reports pass/fail, the first failing entry and the cycle count. A timeout catches hung programs.

Parameters:
- XLEN, 32, data and address width of observed buses.
- DEPTH, 16, number of expected-commit entries (power of two, ≥2).
- TIMEOUT, 1024, maximum RUN cycles before failing.
- IDX_W, $clog2(DEPTH), entry index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- ld_valid  in  1  load an expected entry.
- ld_ready  out  1  entry accepted this cycle when ld_valid&&ld_ready.
- ld_kind  in  1  0=register write, 1=memory store.
- ld_addr  in  XLEN  register index (bits [4:0]) or byte address.
- ld_data  in  XLEN  expected data.
- start  in  1  begin checking / rearm after PASS or FAIL.
- obs_reg_we  in  1  core RegWrite.
- obs_reg_addr  in  5  core A3.
- obs_reg_data  in  XLEN  core WD3.
- obs_mem_we  in  1  core MemWrite.
- obs_mem_addr  in  XLEN  core ALUResult.
- obs_mem_data  in  XLEN  core RD2.
- done  out  1  check finished (sticky).
- pass  out  1  valid when done.
- err_code  out  2  0=none, 1=mismatch, 2=timeout, 3=simultaneous reg+mem event.
- fail_idx  out  IDX_W  entry index at failure.
- fail_got  out  XLEN  observed data at mismatch (0 otherwise).
- cycle_cnt  out  $clog2(TIMEOUT+1)  RUN cycles elapsed.

Behaviour:
- States: IDLE, RUN, PASS, FAIL.
- Reset: state=IDLE; count=0, ptr=0, cycle_cnt=0. done=0, pass=0, err_code=0, fail_idx=0, fail_got=0.
- Reset mid-RUN aborts immediately; the table contents become don't-care because count=0.
- ld_ready = (state==IDLE) && (count<DEPTH) && !rst.
  - An accepted load writes entry[count] and increments count next cycle.
  - Loads while full or outside IDLE are ignored.
- IDLE + start:
  - If count==0: go to PASS next cycle, with done=1, pass=1.
  - Otherwise: go to RUN; ptr=0, cycle_cnt=0.
- ld_valid and start in the same IDLE cycle: the load is accepted and counted before the transition.
- RUN, each cycle:
  - cycle_cnt increments.
  - An event is obs_reg_we with obs_reg_addr!=0, or obs_mem_we. Writes to x0 are ignored.
  - Both events in the same cycle: FAIL, err_code=3, fail_idx=ptr.
  - Single event, match when:
    - kind equals event type,
    - address equals entry address (reg: [4:0] only; mem: full XLEN),
    - data equals entry data.
  - Single event that matches: ptr++. If ptr==count-1, go to PASS.
  - Single event that does not match: FAIL, err_code=1, fail_idx=ptr, fail_got=observed data.
  - No event and cycle_cnt==TIMEOUT-1: FAIL, err_code=2, fail_idx=ptr.
  - Event checks take priority over timeout in the same cycle.
- Latency: done, pass and fail fields are registered, asserted in the cycle after the deciding event is sampled.
- PASS/FAIL are sticky.
  - Observed events are ignored.
  - cycle_cnt is frozen.
  - start returns to IDLE; it clears count, ptr, done, pass, err_code, fail_idx and fail_got.
- Counters never wrap: ptr is bounded by count, cycle_cnt is bounded by TIMEOUT.

Decomposition:
- Package riscv_chk_pkg holds:
  - the state encoding,
  - the err_code constants (ERR_NONE, ERR_MISMATCH, ERR_TIMEOUT, ERR_SIMUL),
  - the kind constants (KIND_REG, KIND_MEM).
- Sub-module chk_exp_mem: DEPTH×(1+2·XLEN) table, synchronous write, asynchronous read by ptr.
- The FSM and compare logic stay in the top.

Test Plan:
- Load {REG,x5,0x0000000A},{MEM,0x10,0x0000000A}; start. Drive reg_we x5=0x0A at cycle 3, then mem_we 0x10/0x0A at cycle 4 → done=1, pass=1, err_code=0, cycle_cnt=5.
- Same table, drive x5=0x0B → FAIL, err_code=1, fail_idx=0, fail_got=0x0000000B one cycle later.
- Writes to x0 interleaved with a correct sequence → ignored; pass=1.
- TIMEOUT=8, one entry, no events → FAIL, err_code=2, fail_idx=0, cycle_cnt=8.
- reg_we and mem_we high in the same RUN cycle → FAIL, err_code=3.
- Load DEPTH+2 entries → ld_ready low after DEPTH loads. Assert rst mid-RUN → all outputs 0, ld_ready=1 the cycle after rst falls. Start with count 0 → pass=1.
